// File: rtl/vgg_pkg.sv
// vgg_pkg: shared widths, operand row types and feeder state encoding for the VGG datapath.
package vgg_pkg;
    localparam int DATA_W = 16;
    localparam int N_OUT  = 7;
    localparam int N_IN   = N_OUT + 2;
    localparam int K      = 3;
    localparam int MAX_CH = 512;
    localparam int FM_AW  = 16;
    localparam int WT_AW  = 16;
    localparam int SLOT_W = $clog2(K * MAX_CH + 1);
    typedef logic [N_IN*DATA_W-1:0] fm_row_t;
    typedef logic [K*DATA_W-1:0] flt_row_t;
    typedef enum logic [1:0] {IDLE, PRIME, RUN, WAIT_OUT} feeder_state_t;
endpackage

// File: rtl/pe_feeder_if.sv
// pe_feeder_if: buffer read ports and PE operand/control signals of the feeder.
interface pe_feeder_if;
    import vgg_pkg::*;
    logic             fm_rd_en;
    logic [FM_AW-1:0] fm_rd_addr;
    fm_row_t          fm_rd_data;
    logic             wt_rd_en;
    logic [WT_AW-1:0] wt_rd_addr;
    flt_row_t         wt_rd_data;
    fm_row_t          input_fm;
    flt_row_t         filter;
    logic             pe_reset;
    logic             output_en;
    modport master (
        output fm_rd_en, fm_rd_addr, wt_rd_en, wt_rd_addr, input_fm, filter, pe_reset,
        input  fm_rd_data, wt_rd_data, output_en
    );
    modport slave (
        input  fm_rd_en, fm_rd_addr, wt_rd_en, wt_rd_addr, input_fm, filter, pe_reset,
        output fm_rd_data, wt_rd_data, output_en
    );
endinterface

// File: rtl/pe_feeder_addr_gen.sv
// feeder_addr_gen: running channel/row address accumulators and the MAC slot counter.
module feeder_addr_gen
    import vgg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [9:0]       num_ch,
    input  logic [FM_AW-1:0] fm_base,
    input  logic [FM_AW-1:0] fm_row_stride,
    input  logic [FM_AW-1:0] fm_ch_stride,
    input  logic [WT_AW-1:0] wt_base,
    input  logic             step,
    input  logic             wrap,
    output logic [FM_AW-1:0] fm_addr,
    output logic [WT_AW-1:0] wt_addr,
    output logic             last_slot
);
    logic [FM_AW-1:0]  ch_acc, row_stride, ch_stride, ch_next;
    logic [1:0]        row;
    logic [SLOT_W-1:0] slot, last;
    assign ch_next   = ch_acc + ch_stride;
    assign last_slot = slot == last;
    // step moves the read pointer to the next slot; wrap moves the slot the PE is consuming
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ch_acc     <= '0;
            fm_addr    <= '0;
            row_stride <= '0;
            ch_stride  <= '0;
            wt_addr    <= '0;
            row        <= '0;
            slot       <= '0;
            last       <= '0;
        end else if (load) begin
            ch_acc     <= fm_base;
            fm_addr    <= fm_base;
            row_stride <= fm_row_stride;
            ch_stride  <= fm_ch_stride;
            wt_addr    <= wt_base;
            row        <= '0;
            slot       <= '0;
            last       <= SLOT_W'({num_ch, 1'b0}) + SLOT_W'(num_ch) - SLOT_W'(1);
        end else begin
            if (step) begin
                ch_acc  <= row == 2'd2 ? ch_next : ch_acc;
                fm_addr <= row == 2'd2 ? ch_next : fm_addr + row_stride;
                row     <= row == 2'd2 ? 2'd0 : row + 2'd1;
                wt_addr <= wt_addr + WT_AW'(1);
            end
            if (wrap) slot <= slot + SLOT_W'(1);
        end
endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: sequences feature-map/filter operand pairs into the 7-output PE, one 4-cycle MAC slot each.
module pe_feeder
    import vgg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [9:0]       num_ch,
    input  logic [FM_AW-1:0] fm_base,
    input  logic [FM_AW-1:0] fm_row_stride,
    input  logic [FM_AW-1:0] fm_ch_stride,
    input  logic [WT_AW-1:0] wt_base,
    output logic             busy,
    output logic             done,
    pe_feeder_if.master      bus
);
    feeder_state_t    state, state_n;
    logic [1:0]       phase;
    logic             active, load, rd, wrap, last_slot, done_z, fin;
    logic [FM_AW-1:0] fm_addr;
    logic [WT_AW-1:0] wt_addr;
    fm_row_t          fm_q;
    flt_row_t         flt_q;
    assign active = state == PRIME || state == RUN;
    assign load   = state == IDLE && start && num_ch != '0;
    assign rd     = phase == 2'd2 && (state == PRIME || (state == RUN && !last_slot));
    assign wrap   = state == RUN && phase == 2'd3;
    assign fin    = state == WAIT_OUT && bus.output_en;
    feeder_addr_gen u_addr (
        .clk(clk), .rst_n(rst_n), .load(load), .num_ch(num_ch),
        .fm_base(fm_base), .fm_row_stride(fm_row_stride), .fm_ch_stride(fm_ch_stride),
        .wt_base(wt_base), .step(rd), .wrap(wrap),
        .fm_addr(fm_addr), .wt_addr(wt_addr), .last_slot(last_slot)
    );
    assign bus.fm_rd_en   = rd;
    assign bus.wt_rd_en   = rd;
    assign bus.fm_rd_addr = rd ? fm_addr : '0;
    assign bus.wt_rd_addr = rd ? wt_addr : '0;
    assign bus.pe_reset   = state == PRIME;
    assign bus.input_fm   = fm_q;
    assign bus.filter     = flt_q;
    assign busy           = state != IDLE && !fin;
    assign done           = done_z || fin;
    always_comb
        state_n = state == IDLE  ? (load ? PRIME : IDLE) :
                  state == PRIME ? (phase == 2'd3 ? RUN : PRIME) :
                  state == RUN   ? (wrap && last_slot ? WAIT_OUT : RUN) :
                  (bus.output_en ? IDLE : WAIT_OUT);
    // read data lands during phase 3; the last slot's wrap clears the operands instead
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            phase  <= '0;
            fm_q   <= '0;
            flt_q  <= '0;
            done_z <= 1'b0;
        end else begin
            state  <= state_n;
            phase  <= active ? phase + 2'd1 : 2'd0;
            done_z <= state == IDLE && start && num_ch == '0;
            if (active && phase == 2'd3) begin
                fm_q  <= wrap && last_slot ? '0 : bus.fm_rd_data;
                flt_q <= wrap && last_slot ? '0 : bus.wt_rd_data;
            end
        end
endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: table-driven and randomized checks of pe_feeder against a cycle-schedule model.
module tb_pe_feeder;
    import vgg_pkg::*;
    typedef struct {
        int         n;
        logic [15:0] fb, rs, cs, wb;
        int         wt;
        bit         noise;
        int         post;
        int         exp_reads;
        logic [15:0] exp_last_fm, exp_last_wt;
        int         exp_done;
    } vec_t;
    typedef logic [228:0] ovec_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, busy, done;
    logic [9:0]  num_ch = '0;
    logic [15:0] fm_base = '0, fm_row_stride = '0, fm_ch_stride = '0, wt_base = '0, cur_wb = '0;
    int          checks = 0, failures = 0;
    vec_t        tbl[6];

    pe_feeder_if bus();
    pe_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_ch(num_ch),
        .fm_base(fm_base), .fm_row_stride(fm_row_stride), .fm_ch_stride(fm_ch_stride),
        .wt_base(wt_base), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic fm_row_t fm_pat(input logic [15:0] a);
        fm_row_t r;
        for (int i = 0; i < N_IN; i++) r[(N_IN-1-i)*DATA_W +: DATA_W] = a ^ 16'(i * 'h1357 + 1);
        return r;
    endfunction

    // buffers answer one cycle after the strobe and return junk otherwise
    always @(posedge clk) begin
        bus.fm_rd_data <= bus.fm_rd_en ? fm_pat(bus.fm_rd_addr)
                                       : {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
        bus.wt_rd_data <= bus.wt_rd_en ? {3{16'(bus.wt_rd_addr - cur_wb)}} : {$urandom, 16'($urandom)};
    end

    function automatic logic [15:0] slot_fm(input int s, input logic [15:0] fb, rs, cs);
        return fb + 16'((s / 3) * cs) + 16'((s % 3) * rs);
    endfunction

    function automatic ovec_t exp_vec(input int t, n, input logic [15:0] fb, rs, cs, wb, input int tw);
        logic rd, pr, bz, dn;
        logic [15:0] fa, wa;
        fm_row_t fi;
        flt_row_t fl;
        int s;
        s  = (t - 3) / 4;
        rd = n > 0 && t >= 3 && (t - 3) % 4 == 0 && s < 3 * n;
        fa = rd ? slot_fm(s, fb, rs, cs) : '0;
        wa = rd ? wb + 16'(s) : '0;
        pr = n > 0 && t >= 1 && t <= 4;
        bz = n > 0 && t < tw;
        dn = t == tw;
        fi = '0;
        fl = '0;
        if (n > 0 && t >= 5 && t < 5 + 12 * n) begin
            s  = (t - 5) / 4;
            fi = fm_pat(slot_fm(s, fb, rs, cs));
            fl = {3{16'(s)}};
        end
        return {rd, fa, rd, wa, pr, bz, dn, fi, fl};
    endfunction

    function automatic ovec_t act_vec();
        return {bus.fm_rd_en, bus.fm_rd_addr, bus.wt_rd_en, bus.wt_rd_addr, bus.pe_reset,
                busy, done, bus.input_fm, bus.filter};
    endfunction

    task automatic chk(input string nm, input ovec_t a, input ovec_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic run_job(input int n, input logic [15:0] fb, rs, cs, wb, input int wt,
                           input bit noise, input int post,
                           output int reads, output logic [15:0] lfm, lwt, output int done_t);
        int tw;
        tw = n == 0 ? 1 : 5 + 12 * n + wt;
        num_ch = 10'(n); fm_base = fb; fm_row_stride = rs; fm_ch_stride = cs; wt_base = wb;
        cur_wb = wb; start = 1'b1; bus.output_en = 1'b0;
        reads = 0; lfm = '0; lwt = '0; done_t = 0;
        for (int t = 1; t <= tw + post; t++) begin
            @(posedge clk); #1;
            start = noise && n > 0 && t < tw ? 1'($urandom) : 1'b0;
            bus.output_en = n > 0 && t == tw ? 1'b1 :
                            (noise && n > 0 && t < 5 + 12 * n ? 1'($urandom) : 1'b0);
            if (noise && t == 1) begin
                num_ch = 10'($urandom); fm_base = 16'($urandom); fm_row_stride = 16'($urandom);
                fm_ch_stride = 16'($urandom); wt_base = 16'($urandom);
            end
            @(negedge clk);
            if (bus.fm_rd_en) begin reads++; lfm = bus.fm_rd_addr; lwt = bus.wt_rd_addr; end
            if (done && done_t == 0) done_t = t;
            if (failures < 100)
                chk($sformatf("cycle n=%0d t=%0d", n, t), act_vec(), exp_vec(t, n, fb, rs, cs, wb, tw));
        end
        start = 1'b0; bus.output_en = 1'b0;
    endtask

    initial begin
        int reads, done_t, n, wt;
        logic [15:0] lfm, lwt, fb, rs, cs, wb;
        tbl[0] = '{1, 16'h100, 16'h10, 16'h40, 16'h20, 0, 1'b0, 2, 3, 16'h120, 16'h22, 17};
        tbl[1] = '{2, 16'h100, 16'h10, 16'h40, 16'h20, 50, 1'b1, 2, 6, 16'h160, 16'h25, 79};
        tbl[2] = '{0, 16'h100, 16'h10, 16'h40, 16'h20, 0, 1'b0, 0, 0, 16'h0, 16'h0, 1};
        tbl[3] = '{1, 16'hFFF0, 16'h10, 16'h8, 16'hFFFF, 3, 1'b0, 1, 3, 16'h0010, 16'h0001, 20};
        tbl[4] = '{3, 16'h1000, 16'h100, 16'h20, 16'h400, 7, 1'b1, 1, 9, 16'h1240, 16'h408, 48};
        tbl[5] = '{512, 16'h0, 16'h3, 16'h11, 16'h100, 1, 1'b0, 1, 1536, 16'h21F5, 16'h6FF, 6150};
        bus.output_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", act_vec(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", act_vec(), '0);
        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i].n, tbl[i].fb, tbl[i].rs, tbl[i].cs, tbl[i].wb, tbl[i].wt,
                    tbl[i].noise, tbl[i].post, reads, lfm, lwt, done_t);
            chk($sformatf("vec%0d reads", i), ovec_t'(reads), ovec_t'(tbl[i].exp_reads));
            chk($sformatf("vec%0d last_fm", i), ovec_t'(lfm), ovec_t'(tbl[i].exp_last_fm));
            chk($sformatf("vec%0d last_wt", i), ovec_t'(lwt), ovec_t'(tbl[i].exp_last_wt));
            chk($sformatf("vec%0d done_cycle", i), ovec_t'(done_t), ovec_t'(tbl[i].exp_done));
        end
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 6); wt = $urandom_range(0, 10);
            fb = 16'($urandom); rs = 16'($urandom); cs = 16'($urandom); wb = 16'($urandom);
            run_job(n, fb, rs, cs, wb, wt, 1'b1, 1, reads, lfm, lwt, done_t);
            chk($sformatf("rand%0d reads", k), ovec_t'(reads), ovec_t'(3 * n));
            chk($sformatf("rand%0d done_cycle", k), ovec_t'(done_t), ovec_t'(5 + 12 * n + wt));
        end
        // abandon a tile in RUN slot 2 phase 1
        num_ch = 10'd2; fm_base = 16'h100; fm_row_stride = 16'h10; fm_ch_stride = 16'h40;
        wt_base = 16'h20; cur_wb = 16'h20; start = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk($sformatf("pre_reset t=%0d", t), act_vec(),
                exp_vec(t, 2, 16'h100, 16'h10, 16'h40, 16'h20, 1000));
        end
        rst_n = 1'b0;
        #1;
        chk("async_reset", act_vec(), '0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", act_vec(), '0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_reset_idle", act_vec(), '0);
        end
        run_job(1, 16'h200, 16'h8, 16'h30, 16'h50, 2, 1'b0, 1, reads, lfm, lwt, done_t);
        chk("after_reset reads", ovec_t'(reads), ovec_t'(3));
        chk("after_reset last_fm", ovec_t'(lfm), ovec_t'(16'h210));
        chk("after_reset done_cycle", ovec_t'(done_t), ovec_t'(19));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
